// File: rtl/ram16_req_ctrl_pkg.sv
// Shared constants and enums for the 16x16 RAM request front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram16_ctrl_pkg;

  localparam int DW        = 16;
  localparam int AW        = 4;
  localparam int RSP_DEPTH = 4;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Reset value GNT_RD makes the first contended grant go to the write side.
  typedef enum logic [0:0] {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/ram16_req_ctrl_if.sv
// Request/response and RAM pin bundle around the RAM request controller.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on wr, rd and rsp channels; RAM pins have none.
interface ram16_req_ctrl_if
  import ram16_ctrl_pkg::*;
#(
  parameter int DW = ram16_ctrl_pkg::DW,
  parameter int AW = ram16_ctrl_pkg::AW
);

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_r_en;
  logic          ram_w_en;
  logic [DW-1:0] ram_rdata;

  // Controller side: accepts requests, produces responses, drives the RAM.
  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr,
    input  rsp_ready,
    input  ram_rdata,
    output wr_ready, rd_ready,
    output rsp_valid, rsp_data,
    output ram_addr, ram_wdata, ram_r_en, ram_w_en
  );

  // Requester plus RAM side.
  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr,
    output rsp_ready,
    output ram_rdata,
    input  wr_ready, rd_ready,
    input  rsp_valid, rsp_data,
    input  ram_addr, ram_wdata, ram_r_en, ram_w_en
  );

endinterface

// File: rtl/ram16_req_ctrl_rsp_fifo.sv
// Small synchronous FIFO buffering RAM read data for the response channel.
// Latency: pushed word is visible at the head the cycle after the push edge.
// Backpressure: pop ignored when empty; a push into a full FIFO is an error.
module ram16_rsp_fifo
  import ram16_ctrl_pkg::*;
#(
  parameter int DW        = ram16_ctrl_pkg::DW,
  parameter int RSP_DEPTH = ram16_ctrl_pkg::RSP_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [DW-1:0]                    push_data,
  input  logic                             pop,
  output logic [DW-1:0]                    pop_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(RSP_DEPTH+1)-1:0]   count
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [DW-1:0] mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(RSP_DEPTH));
  assign empty    = (count == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit accounting reserves a slot for every read in flight.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/ram16_req_ctrl.sv
// Arbitrates write/read requests into single-cycle 16x16 RAM commands; optional RAM16_CLEAR_EN zero-fills the RAM after reset.
// Latency: read accept to rsp_valid is 2 cycles (command reg, RAM d_out reg, capture).
// Backpressure: reads accepted only while FIFO count + reads in flight < RSP_DEPTH, so rsp_ready=0 never loses data.
module ram16_req_ctrl
  import ram16_ctrl_pkg::*;
#(
  parameter int DW        = ram16_ctrl_pkg::DW,
  parameter int AW        = ram16_ctrl_pkg::AW,
  parameter int RSP_DEPTH = ram16_ctrl_pkg::RSP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ram16_req_ctrl_if.slave        bus,
  output logic                   init_done
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  localparam logic [0:0] ST_CLEAR = CLEAR;
  localparam logic [0:0] ST_RUN   = RUN;
`ifdef RAM16_CLEAR_EN
  localparam logic [0:0] ST_RESET = ST_CLEAR;
`else
  localparam logic [0:0] ST_RESET = ST_RUN;
`endif

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  grant_t        last_grant;

  logic          ram_r_en_q;
  logic          ram_w_en_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic          cap_pend;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;

  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          accept_en;
  logic          wr_elig;
  logic          rd_elig;
  logic          wr_gnt;
  logic          rd_gnt;
  logic          clear_wr;
  logic [AW-1:0] clear_addr;

`ifdef RAM16_CLEAR_EN
  // Counter walks 0..2**AW-1; its top bit marks the sweep as finished.
  logic [AW:0]   clr_cnt;

  // Advance the zero-fill address once per cycle while clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_cnt <= '0;
    else if (state == ST_CLEAR && !clr_cnt[AW]) clr_cnt <= clr_cnt + 1'b1;
  end

  // Leave CLEAR once the last zero-write has been issued to the RAM.
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_cnt[AW]) state_nxt = ST_RUN;
  end

  assign clear_wr   = (state == ST_CLEAR) && !clr_cnt[AW];
  assign clear_addr = clr_cnt[AW-1:0];
`else
  assign state_nxt  = state;
  assign clear_wr   = 1'b0;
  assign clear_addr = '0;
`endif

  // Mode register; init_done tracks entry into RUN on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == ST_RUN);
    end
  end

  // A read is eligible only if its response has a guaranteed FIFO slot.
  assign credit_used = {1'b0, fifo_count}
                     + {{CW{1'b0}}, ram_r_en_q}
                     + {{CW{1'b0}}, cap_pend};
  assign credit_ok   = (credit_used < (CW+1)'(RSP_DEPTH)) && !fifo_full;

  assign accept_en = rst_n && init_done && (state == ST_RUN);
  assign wr_elig   = bus.wr_valid;
  assign rd_elig   = bus.rd_valid && credit_ok;
  assign wr_gnt    = accept_en && wr_elig && (!rd_elig || last_grant == GNT_RD);
  assign rd_gnt    = accept_en && rd_elig && (!wr_elig || last_grant == GNT_WR);

  assign bus.wr_ready = wr_gnt;
  assign bus.rd_ready = rd_gnt;

  // Register one RAM command per cycle; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_r_en_q  <= 1'b0;
      ram_w_en_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      last_grant  <= GNT_RD;
    end else begin
      ram_r_en_q <= 1'b0;
      ram_w_en_q <= 1'b0;
      if (clear_wr) begin
        ram_w_en_q  <= 1'b1;
        ram_addr_q  <= clear_addr;
        ram_wdata_q <= '0;
      end else if (wr_gnt) begin
        ram_w_en_q  <= 1'b1;
        ram_addr_q  <= bus.wr_addr;
        ram_wdata_q <= bus.wr_data;
        last_grant  <= GNT_WR;
      end else if (rd_gnt) begin
        ram_r_en_q  <= 1'b1;
        ram_addr_q  <= bus.rd_addr;
        last_grant  <= GNT_RD;
      end
    end
  end

  // RAM registers d_out on the edge after r_en; capture it one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cap_pend <= 1'b0;
    else        cap_pend <= ram_r_en_q;
  end

  assign bus.ram_r_en  = ram_r_en_q;
  assign bus.ram_w_en  = ram_w_en_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

  ram16_rsp_fifo #(
    .DW        (DW),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cap_pend),
    .push_data (bus.ram_rdata),
    .pop       (bus.rsp_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_data  = fifo_head;

endmodule

// File: tb/tb_ram16_req_ctrl.sv
// Directed-plus-random bench for ram16_req_ctrl with a behavioural RAM and reference model.
// Latency: checks the 2-cycle read accept to response timing.
// Backpressure: exercises rsp_ready=0 credit stall and random response stalls.
module tb_ram16_req_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;

  always #5 clk = ~clk;

  ram16_req_ctrl_if #(.DW(16), .AW(4)) bus ();

  ram16_req_ctrl #(.DW(16), .AW(4), .RSP_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .init_done (init_done)
  );

  // Behavioural 16x16 synchronous RAM; idle d_out shows a junk pattern.
  logic [15:0] ram_mem [16];
  logic [15:0] ram_q;
  logic        ram_qv;

  always @(posedge clk) begin
    if (bus.ram_w_en) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_r_en) ram_q <= ram_mem[bus.ram_addr];
    ram_qv <= bus.ram_r_en;
  end

  assign bus.ram_rdata = ram_qv ? ram_q : 16'hDEAD;

  // Reference model: memory image plus queue of expected responses.
  logic [15:0] mem_m [16];
  logic [15:0] exp_q [$];

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  int both_en = 0;
  logic wr_hs;
  logic rd_hs;

  always @(negedge clk) begin
    if (bus.ram_r_en === 1'b1 && bus.ram_w_en === 1'b1) both_en++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, update model, return #1 after the edge.
  task automatic step();
    @(negedge clk);
    wr_hs = bus.wr_valid && bus.wr_ready;
    rd_hs = bus.rd_valid && bus.rd_ready;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL rsp_extra: observed=%0h expected=no response", bus.rsp_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("rsp_data", 32'(bus.rsp_data), 32'(e));
        n_pop++;
      end
    end
    if (wr_hs) mem_m[bus.wr_addr] = bus.wr_data;
    if (rd_hs) exp_q.push_back(mem_m[bus.rd_addr]);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.wr_valid  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (8) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  // Release from reset up to the point the controller accepts requests.
  task automatic bring_up();
`ifdef RAM16_CLEAR_EN
    begin
      int ncyc;
      int nwr;
      int rdy_seen;
      bit done;
      ncyc = 0; nwr = 0; rdy_seen = 0; done = 1'b0;
      bus.wr_valid = 1'b1;
      bus.rd_valid = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
        @(negedge clk);
        if (bus.wr_ready || bus.rd_ready) rdy_seen++;
        if (bus.ram_w_en) begin
          chk("clr_addr", 32'(bus.ram_addr), 32'(nwr));
          chk("clr_wdata", 32'(bus.ram_wdata), 32'd0);
          nwr++;
        end
        @(posedge clk);
        #1;
        ncyc++;
        if (init_done) done = 1'b1;
      end
      chk("clr_cycles", 32'(ncyc), 32'd17);
      chk("clr_writes", 32'(nwr), 32'd16);
      chk("clr_ready_low", 32'(rdy_seen), 32'd0);
      for (int a = 0; a < 16; a++) mem_m[a] = 16'h0000;
    end
`else
    bus.wr_valid = 1'b1;
    bus.rd_valid = 1'b1;
    @(negedge clk);
    chk("pre_init_done", 32'(init_done), 32'd0);
    chk("pre_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("pre_rd_ready", 32'(bus.rd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("init_done", 32'(init_done), 32'd1);
`endif
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int pop0;
    int stale;

    rst_n         = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.rd_valid  = 1'b1;
    bus.wr_addr   = 4'd0;
    bus.wr_data   = 16'h0;
    bus.rd_addr   = 4'd0;
    bus.rsp_ready = 1'b0;
    for (int a = 0; a < 16; a++) mem_m[a] = 16'hxxxx;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_r_en", 32'(bus.ram_r_en), 32'd0);
    chk("rst_w_en", 32'(bus.ram_w_en), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
    rst_n = 1'b1;
    bring_up();

    // Write addr 3 then read it back; response exactly 2 cycles after accept
    bus.wr_valid = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hA5A5;
    step();
    chk("w3_accept", 32'(wr_hs), 32'd1);
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr = 4'd3;
    step();
    chk("r3_accept", 32'(rd_hs), 32'd1);
    bus.rd_valid = 1'b0;
    chk("r3_cmd_r_en", 32'(bus.ram_r_en), 32'd1);
    chk("r3_cmd_addr", 32'(bus.ram_addr), 32'd3);
    chk("r3_lat0_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("r3_lat1_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("r3_lat2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("r3_lat2_data", 32'(bus.rsp_data), 32'hA5A5);
    bus.rsp_ready = 1'b1;
    step();
    chk("r3_popped", 32'(n_pop), 32'd1);

    // Contention: both valid for 8 cycles, grants alternate starting with write
    bus.wr_valid = 1'b1; bus.rd_valid = 1'b1; bus.rd_addr = 4'd3;
    for (int i = 0; i < 8; i++) begin
      bus.wr_addr = 4'(4 + i);
      bus.wr_data = 16'($urandom);
      step();
      chk("cont_wr_grant", 32'(wr_hs), 32'((i % 2) == 0));
      chk("cont_rd_grant", 32'(rd_hs), 32'((i % 2) == 1));
    end
    drain();

    // Fill the whole memory with random data
    bus.wr_valid = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.wr_addr = 4'(a);
      bus.wr_data = 16'($urandom);
      step();
      chk("fill_accept", 32'(wr_hs), 32'd1);
    end
    bus.wr_valid = 1'b0;

    // Back-pressure: only RSP_DEPTH reads accepted while rsp_ready is low
    bus.rsp_ready = 1'b0;
    pop0 = n_pop;
    idx  = 0;
    for (int c = 0; c < 10; c++) begin
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 4'(idx);
      step();
      if (rd_hs) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_rd_ready", 32'(bus.rd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 60 && (idx < 8 || exp_q.size() > 0); n++) begin
      bus.rd_valid = (idx < 8);
      bus.rd_addr  = 4'(idx);
      step();
      if (rd_hs) idx++;
    end
    bus.rd_valid = 1'b0;
    chk("bp_total_reads", 32'(idx), 32'd8);
    chk("bp_total_rsp", 32'(n_pop - pop0), 32'd8);

    // Streaming: 16 back-to-back reads, one accept per cycle
    pop0 = n_pop;
    for (int a = 0; a < 16; a++) begin
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 4'(a);
      step();
      chk("stream_accept", 32'(rd_hs), 32'd1);
    end
    drain();
    chk("stream_rsp_count", 32'(n_pop - pop0), 32'd16);

    // Random mixed traffic with random response stalls
    for (int i = 0; i < 80; i++) begin
      bus.wr_valid  = 1'($urandom_range(0, 1));
      bus.wr_addr   = 4'($urandom_range(0, 15));
      bus.wr_data   = 16'($urandom);
      bus.rd_valid  = 1'($urandom_range(0, 1));
      bus.rd_addr   = 4'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Reset one cycle after a read is accepted: nothing in flight survives
    bus.rsp_ready = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr = 4'd5;
    step();
    chk("mid_rd0_accept", 32'(rd_hs), 32'd1);
    bus.rd_addr = 4'd6;
    step();
    chk("mid_rd1_accept", 32'(rd_hs), 32'd1);
    bus.rd_valid = 1'b0;
    chk("mid_pre_r_en", 32'(bus.ram_r_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_r_en", 32'(bus.ram_r_en), 32'd0);
    chk("mid_w_en", 32'(bus.ram_w_en), 32'd0);
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bring_up();
    bus.rsp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid) stale++;
      step();
    end
    chk("mid_no_stale_rsp", 32'(stale), 32'd0);

    // Post-reset read sanity (zeroed RAM when clearing, else kept contents)
    bus.rd_valid = 1'b1; bus.rd_addr = 4'd9;
    step();
    chk("post_rd_accept", 32'(rd_hs), 32'd1);
    drain();

    chk("never_both_enables", 32'(both_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
